// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR scheduler: state width, feedback taps,
// scheduler state encoding and the single-step LFSR function.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned TAP_A  = 31;
  localparam int unsigned TAP_B  = 21;
  localparam int unsigned TAP_C  = 1;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Fibonacci step for x^32 + x^22 + x^2 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C]};
  endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_rr_sched_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// ptr_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_oh_c_o,
  output logic [PW-1:0]   win_idx_c_o,
  output logic            win_any_c_o
);

  always_comb begin
    win_any_c_o = 1'b0;
    win_idx_c_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned cand;
      cand = (32'(ptr_i) + i) % NREQ;
      if (!win_any_c_o && req_i[PW'(cand)]) begin
        win_any_c_o = 1'b1;
        win_idx_c_o = PW'(cand);
      end
    end
    win_oh_c_o = win_any_c_o ? (NREQ'(1) << win_idx_c_o) : '0;
  end

endmodule : rr_pick

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one 32-bit LFSR among NREQ requesters, with
// seed load, zero-seed rejection and post-seed warm-up.
// Optional grant counter output enabled by LFSR_RR_GNT_CNT_EN.
module lfsr_rr_sched
  import lfsr_pkg::*;
#(
  parameter int unsigned       NREQ       = 4,
  parameter int unsigned       WARMUP     = 8,
  parameter logic [LFSR_W-1:0] RESET_SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_in_i,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [LFSR_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              busy_o,
`ifdef LFSR_RR_GNT_CNT_EN
  output logic [15:0]       gnt_cnt_o,
`endif
  output logic              seed_err_o
);

  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WCW = 8;
  localparam int unsigned GCW = 16;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [WCW-1:0]      warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [LFSR_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                seed_err_q, seed_err_d;

  logic [NREQ-1:0]     win_oh;
  logic [PW-1:0]       win_idx;
  logic                win_any;
  logic                warm_done;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i       (req_i),
    .ptr_i       (rr_ptr_q),
    .win_oh_c_o  (win_oh),
    .win_idx_c_o (win_idx),
    .win_any_c_o (win_any)
  );

  assign warm_done = (warm_cnt_q == WCW'(WARMUP - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WARM;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_we_i) begin
      state_d = WARM;
    end else begin
      case (state_q)
        WARM:    if (warm_done) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = WARM;
      endcase
    end
  end

  // Datapath next values; seed load outranks both warm-up and arbitration
  always_comb begin
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    rdata_d    = '0;
    rvalid_d   = 1'b0;
    seed_err_d = 1'b0;
    if (seed_we_i) begin
      seed_err_d = (seed_in_i == '0);
      lfsr_d     = (seed_in_i == '0) ? LFSR_W'(1) : seed_in_i;
      warm_cnt_d = '0;
    end else if (state_q == WARM) begin
      lfsr_d     = lfsr_next(lfsr_q);
      warm_cnt_d = warm_done ? '0 : warm_cnt_q + WCW'(1);
    end else if (win_any) begin
      gnt_d    = win_oh;
      rdata_d  = lfsr_q;
      rvalid_d = 1'b1;
      lfsr_d   = lfsr_next(lfsr_q);
      rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q     <= RESET_SEED;
      warm_cnt_q <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      seed_err_q <= seed_err_d;
    end
  end

`ifdef LFSR_RR_GNT_CNT_EN
  logic [GCW-1:0] gnt_cnt_q, gnt_cnt_d;

  // Counts grants in the same edge they are issued; wraps naturally
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (seed_we_i)     gnt_cnt_d = '0;
    else if (rvalid_d) gnt_cnt_d = gnt_cnt_q + GCW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gnt_cnt_q <= '0;
    else      gnt_cnt_q <= gnt_cnt_d;
  end

  assign gnt_cnt_o = gnt_cnt_q;
`endif

  assign gnt_o      = gnt_q;
  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign busy_o     = (state_q == WARM);
  assign seed_err_o = seed_err_q;

endmodule : lfsr_rr_sched
